// File: rtl/alu_pkg.sv
// Shared constants for the ALU sharing front-end: op codes, FSM states and
// the bit positions of the captured flag vector.
package alu_pkg;

  localparam logic [2:0] OP_ADD = 3'd0;
  localparam logic [2:0] OP_SUB = 3'd1;
  localparam logic [2:0] OP_NOT = 3'd2;
  localparam logic [2:0] OP_AND = 3'd3;
  localparam logic [2:0] OP_OR  = 3'd4;
  localparam logic [2:0] OP_XOR = 3'd5;
  localparam logic [2:0] OP_GT  = 3'd6;
  localparam logic [2:0] OP_EQ  = 3'd7;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_e;

  localparam int CARRY = 3;
  localparam int OVF   = 2;
  localparam int ZERO  = 1;
  localparam int NEG   = 0;

endpackage

// File: rtl/rr_arb2.sv
// Two-requester round-robin grant: a lone requester always wins, a tie goes
// to the requester named by rr_ptr.
module rr_arb2 (
  input  logic [1:0] req_valid,
  input  logic       rr_ptr,
  output logic       grant_id,
  output logic       grant_valid
);

  assign grant_valid = |req_valid;
  assign grant_id    = (req_valid == 2'b11) ? rr_ptr : req_valid[1];

endmodule

// File: rtl/alu_share_ctrl.sv
// Front-end that time-shares one combinational ALU between two requesters:
// arbitrate, drive the ALU for one cycle, return the result on valid/ready.
module alu_share_ctrl
  import alu_pkg::*;
#(
  parameter int WIDTH = 4,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             clrn,
  input  logic [1:0]       req_valid,
  input  logic [2:0]       req_op0,
  input  logic [2:0]       req_op1,
  input  logic [WIDTH-1:0] req_a0,
  input  logic [WIDTH-1:0] req_b0,
  input  logic [WIDTH-1:0] req_a1,
  input  logic [WIDTH-1:0] req_b1,
  output logic [1:0]       req_ready,
  output logic [2:0]       alu_select,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  input  logic [WIDTH-1:0] alu_res,
  input  logic             alu_carry,
  input  logic             alu_overflow,
  input  logic             alu_zero,
  input  logic             alu_negative,
  output logic             resp_valid,
  input  logic             resp_ready,
  output logic             resp_id,
  output logic [WIDTH-1:0] resp_res,
  output logic [3:0]       resp_flags,
  output logic             busy,
  output logic [CNT_W-1:0] op_count
);

  state_e state_reg, state_next;
  logic   rr_ptr_reg;
  logic   owner_reg;
  logic   grant_id, grant_valid;
  logic   accept, handshake;

  rr_arb2 u_arb (
    .req_valid  (req_valid),
    .rr_ptr     (rr_ptr_reg),
    .grant_id   (grant_id),
    .grant_valid(grant_valid)
  );

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) state_reg <= IDLE;
    else       state_reg <= state_next;
  end

  // Gating ready with clrn keeps req_ready low while reset is asserted even
  // if a requester is already presenting valid.
  always_comb begin
    state_next = state_reg;
    req_ready  = 2'b00;
    accept     = 1'b0;
    handshake  = 1'b0;
    case (state_reg)
      IDLE: begin
        if (grant_valid && clrn) begin
          req_ready[grant_id] = 1'b1;
          accept              = 1'b1;
          state_next          = EXEC;
        end
      end
      EXEC: state_next = RESP;
      RESP: begin
        if (resp_valid && resp_ready) begin
          handshake  = 1'b1;
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      rr_ptr_reg <= 1'b0;
      owner_reg  <= 1'b0;
      alu_select <= '0;
      alu_a      <= '0;
      alu_b      <= '0;
      resp_valid <= 1'b0;
      resp_id    <= 1'b0;
      resp_res   <= '0;
      resp_flags <= '0;
      op_count   <= '0;
    end else begin
      if (accept) begin
        alu_select <= grant_id ? req_op1 : req_op0;
        alu_a      <= grant_id ? req_a1  : req_a0;
        alu_b      <= grant_id ? req_b1  : req_b0;
        owner_reg  <= grant_id;
      end
      // ALU inputs have been stable for a full cycle by the end of EXEC.
      if (state_reg == EXEC) begin
        resp_res          <= alu_res;
        resp_flags[CARRY] <= alu_carry;
        resp_flags[OVF]   <= alu_overflow;
        resp_flags[ZERO]  <= alu_zero;
        resp_flags[NEG]   <= alu_negative;
        resp_valid        <= 1'b1;
        resp_id           <= owner_reg;
      end
      if (handshake) begin
        resp_valid <= 1'b0;
        op_count   <= op_count + CNT_W'(1);
        rr_ptr_reg <= ~owner_reg;
      end
    end
  end

  assign busy = (state_reg != IDLE);

endmodule
